// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, latencies
// and small decode helpers used by both the sequencer and the decoder.
package mdu_pkg;

  typedef enum logic [2:0] {
    MDU_MULT  = 3'b000,
    MDU_MULTU = 3'b001,
    MDU_DIV   = 3'b010,
    MDU_DIVU  = 3'b011,
    MDU_MTHI  = 3'b100,
    MDU_MTLO  = 3'b101,
    MDU_MFHI  = 3'b110,
    MDU_MFLO  = 3'b111
  } mdu_op_e;

  localparam int MULT_LAT = 5;
  localparam int DIV_LAT  = 10;
  localparam int CNT_W    = 4;

  function automatic logic is_div(input mdu_op_e op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

  function automatic logic [CNT_W-1:0] op_latency(input mdu_op_e op);
    return is_div(op) ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// Purely combinational 64-bit multiply and 32-bit divide datapath.
// Results are consumed by the sequencer on the final cycle of an operation.
module mdu_arith
  import mdu_pkg::*;
(
  input  mdu_op_e     op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] hi_res,
  output logic [31:0] lo_res,
  output logic        div0
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] b_div;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] quot;
  logic [31:0] rem;

  always_comb begin
    prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    prod_u = {32'd0, a} * {32'd0, b};

    // Signed division runs on magnitudes; 0x80000000 has magnitude
    // 0x80000000 unsigned, which makes the overflow case fall out naturally.
    a_neg = (op == MDU_DIV) && a[31];
    b_neg = (op == MDU_DIV) && b[31];
    a_mag = a_neg ? (32'd0 - a) : a;
    b_mag = b_neg ? (32'd0 - b) : b;
    div0  = (b == 32'd0);
    b_div = div0 ? 32'd1 : b_mag;
    q_mag = a_mag / b_div;
    r_mag = a_mag % b_div;
    quot  = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
    rem   = a_neg ? (32'd0 - r_mag) : r_mag;

    hi_res = 32'd0;
    lo_res = 32'd0;
    case (op)
      MDU_MULT: begin
        hi_res = prod_s[63:32];
        lo_res = prod_s[31:0];
      end
      MDU_MULTU: begin
        hi_res = prod_u[63:32];
        lo_res = prod_u[31:0];
      end
      MDU_DIV, MDU_DIVU: begin
        hi_res = rem;
        lo_res = quot;
      end
      default: begin
        hi_res = 32'd0;
        lo_res = 32'd0;
      end
    endcase
  end

endmodule

// File: rtl/mdu_sequencer.sv
// Multi-cycle MDU sequencer: latches operands on issue, counts down the
// fixed latency, then commits HI/LO. Also handles mthi/mtlo and mfhi/mflo.
module mdu_sequencer
  import mdu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        mt,
  input  logic [2:0]  MDU_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        D_mdu_use,
  output logic        busy,
  output logic        stall,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MDU_out
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      a_q, a_d;
  logic [31:0]      b_q, b_d;
  mdu_op_e          op_q, op_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic             busy_q, busy_d;

  mdu_op_e          op_in;
  logic [31:0]      hi_res;
  logic [31:0]      lo_res;
  logic             div0;

  assign op_in = mdu_op_e'(MDU_op);

  mdu_arith u_arith (
    .op     (op_q),
    .a      (a_q),
    .b      (b_q),
    .hi_res (hi_res),
    .lo_res (lo_res),
    .div0   (div0)
  );

  always_comb begin
    cnt_d = cnt_q;
    a_d   = a_q;
    b_d   = b_q;
    op_d  = op_q;
    hi_d  = hi_q;
    lo_d  = lo_q;

    if (busy_q) begin
      cnt_d = cnt_q - CNT_W'(1);
      // Commit on the 1->0 step; a zero divisor leaves HI/LO untouched.
      if (cnt_q == CNT_W'(1) && !(is_div(op_q) && div0)) begin
        hi_d = hi_res;
        lo_d = lo_res;
      end
    end else if (start) begin
      a_d   = A;
      b_d   = B;
      op_d  = op_in;
      cnt_d = op_latency(op_in);
    end else if (mt) begin
      if (op_in == MDU_MTHI) begin
        hi_d = A;
      end else if (op_in == MDU_MTLO) begin
        lo_d = A;
      end
    end

    busy_d = (cnt_d != '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= MDU_MULT;
      hi_q   <= '0;
      lo_q   <= '0;
      busy_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      a_q    <= a_d;
      b_q    <= b_d;
      op_q   <= op_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      busy_q <= busy_d;
    end
  end

  assign busy  = busy_q;
  assign HI    = hi_q;
  assign LO    = lo_q;
  assign stall = D_mdu_use & (busy_q | start);

  always_comb begin
    case (op_in)
      MDU_MFHI: MDU_out = hi_q;
      MDU_MFLO: MDU_out = lo_q;
      default:  MDU_out = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_mdu_sequencer.sv
// Directed bench for mdu_sequencer: table of back-to-back md operations
// plus hand-written sequences for mt/start interplay, idle hold and reset.
module tb_mdu_sequencer;

  logic        clk;
  logic        reset;
  logic        start;
  logic        mt;
  logic [2:0]  MDU_op;
  logic [31:0] A;
  logic [31:0] B;
  logic        D_mdu_use;
  logic        busy;
  logic        stall;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] MDU_out;

  int checks;
  int errors;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;
  localparam logic [2:0] OP_MFHI  = 3'b110;
  localparam logic [2:0] OP_MFLO  = 3'b111;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          lat;
  } vec_t;

  vec_t vecs[9];

  mdu_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .mt        (mt),
    .MDU_op    (MDU_op),
    .A         (A),
    .B         (B),
    .D_mdu_use (D_mdu_use),
    .busy      (busy),
    .stall     (stall),
    .HI        (HI),
    .LO        (LO),
    .MDU_out   (MDU_out)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // The pipeline never issues start while the unit is busy.
  always @(posedge clk) begin
    if (!reset && start && busy) begin
      errors++;
      $display("FAIL start_while_busy: start=1 seen with busy=1 at %0t", $time);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Called just after a negedge; issues immediately so consecutive calls
  // exercise earliest back-to-back issue.
  task automatic run_md(input vec_t v, input int idx);
    int busy_cnt;
    int stall_cnt;
    start     = 1'b1;
    mt        = 1'b0;
    MDU_op    = v.op;
    A         = v.a;
    B         = v.b;
    D_mdu_use = 1'b1;
    #1;
    stall_cnt = stall ? 1 : 0;
    @(posedge clk);
    @(negedge clk);
    start    = 1'b0;
    busy_cnt = 0;
    while (busy && busy_cnt < 20) begin
      busy_cnt++;
      if (stall) stall_cnt++;
      @(negedge clk);
    end
    check($sformatf("busy_len[%0d]", idx), 32'(busy_cnt), 32'(v.lat));
    check($sformatf("stall_len[%0d]", idx), 32'(stall_cnt), 32'(v.lat + 1));
    check($sformatf("stall_off[%0d]", idx), {31'd0, stall}, 32'd0);
    D_mdu_use = 1'b0;
    MDU_op    = OP_MFHI;
    #1;
    check($sformatf("mfhi[%0d]", idx), MDU_out, v.exp_hi);
    MDU_op = OP_MFLO;
    #1;
    check($sformatf("mflo[%0d]", idx), MDU_out, v.exp_lo);
  endtask

  initial begin
    int      wait_cnt;
    vec_t    tail;
    checks    = 0;
    errors    = 0;
    reset     = 1'b1;
    start     = 1'b0;
    mt        = 1'b0;
    MDU_op    = OP_MFHI;
    A         = 32'd0;
    B         = 32'd0;
    D_mdu_use = 1'b0;

    vecs[0] = '{OP_MULT,  32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFE, 5};
    vecs[1] = '{OP_MULTU, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE, 5};
    vecs[2] = '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    vecs[3] = '{OP_DIVU,  32'h00000007, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    vecs[4] = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
    vecs[5] = '{OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       10};
    vecs[6] = '{OP_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 10};
    vecs[7] = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5};
    vecs[8] = '{OP_MULT,  32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 5};

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_hi", HI, 32'd0);
    check("rst_lo", LO, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_mdu_out", MDU_out, 32'd0);
    reset = 1'b0;

    // First issue lands on the first edge after reset release.
    for (int i = 0; i < 9; i++) begin
      run_md(vecs[i], i);
    end

    // start and mt together: start wins, HI keeps its value (1).
    start  = 1'b1;
    mt     = 1'b1;
    MDU_op = OP_MULT;
    A      = 32'd3;
    B      = 32'd4;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    mt    = 1'b0;
    check("start_mt_prio_hi", HI, 32'd1);
    check("start_mt_busy", {31'd0, busy}, 32'd1);
    mt     = 1'b1;
    MDU_op = OP_MTLO;
    A      = 32'hDEADBEEF;
    @(negedge clk);
    mt = 1'b0;
    check("mtlo_during_busy", LO, 32'd0);
    wait_cnt = 0;
    while (busy && wait_cnt < 20) begin
      wait_cnt++;
      @(negedge clk);
    end
    check("mult34_hi", HI, 32'd0);
    check("mult34_lo", LO, 32'd12);

    // mthi then mfhi
    mt     = 1'b1;
    MDU_op = OP_MTHI;
    A      = 32'h12345678;
    @(negedge clk);
    mt = 1'b0;
    check("mthi_hi", HI, 32'h12345678);
    MDU_op = OP_MFHI;
    #1;
    check("mfhi_after_mthi", MDU_out, 32'h12345678);

    // Idle edges must not disturb state.
    A = 32'hCAFEF00D;
    B = 32'h0BADBEEF;
    repeat (3) @(negedge clk);
    check("idle_hi", HI, 32'h12345678);
    check("idle_lo", LO, 32'd12);
    check("idle_busy", {31'd0, busy}, 32'd0);

    // Reset in busy cycle 3 of a div, between clock edges.
    start  = 1'b1;
    MDU_op = OP_DIV;
    A      = 32'd100;
    B      = 32'd7;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_busy", {31'd0, busy}, 32'd0);
    check("async_rst_hi", HI, 32'd0);
    check("async_rst_lo", LO, 32'd0);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check($sformatf("post_rst_hilo[%0d]", i), HI | LO | {31'd0, busy}, 32'd0);
    end

    tail = '{OP_MULT, 32'd5, 32'hFFFFFFFA, 32'hFFFFFFFF, 32'hFFFFFFE2, 5};
    run_md(tail, 9);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mdu_sequencer.md
MDU_SEQUENCER -- requirements
Module: mdu_sequencer

Interface
REQ-001 SHALL have port clk, input, 1, sole clock, rising-edge.
REQ-002 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port start, input, 1, E-stage mult/multu/div/divu issue strobe (md).
REQ-004 SHALL have port mt, input, 1, E-stage mthi/mtlo write strobe.
REQ-005 SHALL have port MDU_op, input, 3, op code: 000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo, 110 mfhi, 111 mflo.
REQ-006 SHALL have ports A and B, input, 32 each, E-stage forwarded rs/rt operands.
REQ-007 SHALL have port D_mdu_use, input, 1, D-stage instruction is any md/mf/mt.
REQ-008 SHALL have port busy, output, 1, operation in progress.
REQ-009 SHALL have port stall, output, 1, D-stage freeze request.
REQ-010 SHALL have ports HI and LO, output, 32 each, architectural registers.
REQ-011 SHALL have port MDU_out, output, 32, mfhi→HI, mflo→LO, else 0; combinational from MDU_op.

Function
REQ-012 SHALL, on an edge with start=1 and busy=0, latch A, B and op, and load the down-counter with MULT_LAT=5 (mult/multu) or DIV_LAT=10 (div/divu).
REQ-013 SHALL hold busy=1 from the edge after the start edge until the counter reaches 0: exactly 5 cycles for multiply, 10 cycles for divide.
REQ-014 SHALL write HI/LO on the edge at which the counter goes 1→0; busy=0 in the following cycle, so a back-to-back md issues at the earliest then.
REQ-015 SHALL compute mult as signed 32x32→64, multu as unsigned; HI=upper 32 bits, LO=lower 32 bits.
REQ-016 SHALL compute div as signed (quotient truncated toward zero, remainder takes the dividend's sign) and divu as unsigned; LO=quotient, HI=remainder.
REQ-017 SHALL leave HI/LO unchanged when the divisor is 0, while still running the full 10-cycle busy window.
REQ-018 SHALL, for div, evaluate 0x80000000 / 0xFFFFFFFF to LO=0x80000000, HI=0.
REQ-019 SHALL, on mt=1 with busy=0, write A to HI (mthi) or LO (mtlo) at that edge.
REQ-020 SHALL ignore start and mt while busy=1; the pipeline guarantees this never occurs, and the bench asserts it.
REQ-021 SHALL give start priority and drop mt when start and mt coincide.
REQ-022 SHALL drive stall = D_mdu_use & (busy | start), combinationally.
REQ-023 SHALL not change HI/LO, busy or the counter on an edge with start=0, mt=0, busy=0.
REQ-024 SHALL make the result visible via MDU_out in the first cycle after busy falls.

Reset
REQ-025 SHALL, on reset assertion at any time (including mid-operation), immediately clear HI, LO, counter, latched operands and op to 0, and drive busy=0.
REQ-026 SHALL discard an in-flight operation on reset; no HI/LO write occurs after reset deasserts.
REQ-027 SHALL accept start on the first clk edge after reset deasserts.

Structure
REQ-028 SHALL place the MDU_op encodings, MULT_LAT and DIV_LAT in shared package mdu_pkg, also used by the decoder.
REQ-029 SHALL isolate the 64-bit arithmetic in one combinational sub-module, mdu_arith (inputs: op, A, B; outputs: hi_res, lo_res, div0).
REQ-030 SHALL contain in the top level only the counter, operand/op latches and HI/LO registers; no other sub-modules.

Verification
REQ-031 SHALL cover: mult A=0xFFFFFFFF, B=2 -> busy 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE; multu same operands -> HI=1, LO=0xFFFFFFFE.
REQ-032 SHALL cover: div A=-7 (0xFFFFFFF9), B=2 -> busy 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu A=7, B=0 -> HI/LO unchanged after 10 cycles.
REQ-033 SHALL cover: D_mdu_use=1 held from the start cycle -> stall=1 for 6 cycles (start cycle + 5 busy), stall=0 after.
REQ-034 SHALL cover: mthi A=0x12345678 with busy=0 -> HI=0x12345678 next cycle; mfhi -> MDU_out=0x12345678; mtlo during busy -> LO unchanged.
REQ-035 SHALL cover: reset asserted in busy cycle 3 of a div -> busy, HI and LO go 0 immediately with no clk edge, and stay 0 after deassert.
REQ-036 SHALL cover: two back-to-back mults issued at the earliest legal cycle -> second result correct, each busy window exactly 5 cycles.
